// File: rtl/sargantana_icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sargantana_icache_pkg
//  Description : Shared icache geometry, invalidation request, valid-bit
//                write-port bundle and valid-bit controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package sargantana_icache_pkg;

   localparam int unsigned ICACHE_DEPTH        = 64;
   localparam int unsigned ADDR_WIDHT          = $clog2(ICACHE_DEPTH);
   localparam int unsigned ICACHE_N_WAY        = 4;
   localparam int unsigned ICACHE_OFFSET_WIDTH = 4;
   localparam int unsigned ICACHE_INDEX_WIDTH  = ADDR_WIDHT + ICACHE_OFFSET_WIDTH;
   localparam int unsigned PHY_ADDR_SIZE       = 32;

   // Single-line invalidation coming back on the ifill response path
   typedef struct packed {
      logic                     valid;
      logic [PHY_ADDR_SIZE-1:0] paddr;
   } inv_t;

   // One write to the valid-bit array: masked ways of set idx take data
   typedef struct packed {
      logic                    we;
      logic [ADDR_WIDHT-1:0]   idx;
      logic [ICACHE_N_WAY-1:0] way_mask;
      logic [ICACHE_N_WAY-1:0] data;
   } vb_wr_t;

   typedef enum logic [1:0] {
      VB_IDLE  = 2'd0,
      VB_DRAIN = 2'd1,
      VB_SWEEP = 2'd2,
      VB_DONE  = 2'd3
   } vb_state_t;

endpackage
`default_nettype wire

// File: rtl/sargantana_icache_inv_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sargantana_icache_inv_fifo
//  Description : Small FIFO of set indices for invalidations that lost the
//                valid-bit write port to a fill. Clear has priority over
//                push/pop. A push while full is accepted only if a pop
//                frees the slot in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sargantana_icache_inv_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   input  logic             clear_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q;
   logic [PTR_W-1:0] rptr_q;
   logic [PTR_W:0]   cnt_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rptr_q];
   assign do_push = push_i & (~full_o | pop_i);
   assign do_pop  = pop_i & ~empty_o;

   // Pointer and occupancy bookkeeping; clear empties the queue at once
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else if (clear_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + PTR_W'(1);
         if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
            2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid
   always_ff @(posedge clk_i) begin
      if (do_push && !clear_i) mem_q[wptr_q] <= data_i;
   end

endmodule
`default_nettype wire

// File: rtl/sargantana_icache_vb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sargantana_icache_vb_ctrl
//  Description : Sole owner of the valid-bit array write port. Arbitrates
//                fills, single-set invalidations and full-cache sweeps
//                (fence.i and post-reset init); all outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module sargantana_icache_vb_ctrl
   import sargantana_icache_pkg::*;
#(
   parameter int unsigned RESET_SWEEP    = 1,
   parameter int unsigned INV_FIFO_DEPTH = 2,
   parameter int unsigned DEPTH          = ICACHE_DEPTH
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    flush_i,
   input  logic                    ctrl_idle_i,
   input  logic                    fill_we_i,
   input  logic [ADDR_WIDHT-1:0]   fill_idx_i,
   input  logic [ICACHE_N_WAY-1:0] fill_way_i,
   input  inv_t                    inv_i,
   output logic                    busy_o,
   output logic                    flush_done_o,
   output vb_wr_t                  vb_wr_o
);

   localparam vb_state_t             c_reset_state = (RESET_SWEEP != 0) ? VB_SWEEP : VB_IDLE;
   localparam logic                  c_reset_busy  = (RESET_SWEEP != 0);
   localparam logic [ADDR_WIDHT-1:0] c_last_idx    = ADDR_WIDHT'(DEPTH - 1);

   vb_state_t             state_q, state_d;
   logic [ADDR_WIDHT-1:0] cnt_q, cnt_d;
   logic                  flush_pend_q, flush_pend_d;
   vb_wr_t                vb_wr_q, vb_wr_d;
   logic                  busy_q, busy_d;
   logic                  flush_done_q, flush_done_d;

   logic                  in_sweep;
   logic [ADDR_WIDHT-1:0] inv_idx;
   logic                  fifo_push_req, fifo_push, fifo_pop, fifo_clear;
   logic                  fifo_full, fifo_empty;
   logic [ADDR_WIDHT-1:0] fifo_head;
   logic                  unused_inv_paddr;

   assign in_sweep = (state_q == VB_SWEEP);
   assign inv_idx  = inv_i.paddr[ICACHE_INDEX_WIDTH-1:ICACHE_OFFSET_WIDTH];
   assign unused_inv_paddr = ^{inv_i.paddr[PHY_ADDR_SIZE-1:ICACHE_INDEX_WIDTH],
                               inv_i.paddr[ICACHE_OFFSET_WIDTH-1:0]};

   sargantana_icache_inv_fifo #(
      .DEPTH (INV_FIFO_DEPTH),
      .WIDTH (ADDR_WIDHT)
   ) u_inv_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .data_i  (inv_idx),
      .pop_i   (fifo_pop),
      .clear_i (fifo_clear),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (fifo_head)
   );

   // State register: FSM, sweep counter and deferred-flush flag
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= c_reset_state;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   // Next state: a flush that lands mid-sweep re-runs the whole sweep
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      flush_pend_d = flush_pend_q;
      case (state_q)
         VB_IDLE: begin
            if (flush_i) state_d = ctrl_idle_i ? VB_SWEEP : VB_DRAIN;
         end
         VB_DRAIN: begin
            if (ctrl_idle_i) state_d = VB_SWEEP;
         end
         VB_SWEEP: begin
            if (flush_i) flush_pend_d = 1'b1;
            if (cnt_q == c_last_idx) begin
               cnt_d   = '0;
               state_d = VB_DONE;
            end else begin
               cnt_d = cnt_q + ADDR_WIDHT'(1);
            end
         end
         VB_DONE: begin
            cnt_d = '0;
            if (flush_pend_q || flush_i) begin
               state_d      = VB_DRAIN;
               flush_pend_d = 1'b0;
            end else begin
               state_d = VB_IDLE;
            end
         end
         default: state_d = VB_IDLE;
      endcase
   end

   // Outputs: sweep owns the port, otherwise fill > queued inv > new inv
   always_comb begin
      vb_wr_d       = '0;
      fifo_push_req = 1'b0;
      fifo_pop      = 1'b0;
      fifo_clear    = (state_d == VB_SWEEP) && !in_sweep;
      busy_d        = (state_q != VB_IDLE);
      flush_done_d  = (state_q == VB_DONE);
      if (in_sweep) begin
         vb_wr_d.we       = 1'b1;
         vb_wr_d.idx      = cnt_q;
         vb_wr_d.way_mask = '1;
         vb_wr_d.data     = '0;
      end else begin
         fifo_pop      = !fill_we_i && !fifo_empty;
         fifo_push_req = inv_i.valid && (fill_we_i || !fifo_empty);
         if (fill_we_i) begin
            vb_wr_d.we       = 1'b1;
            vb_wr_d.idx      = fill_idx_i;
            vb_wr_d.way_mask = fill_way_i;
            vb_wr_d.data     = '1;
         end else if (!fifo_empty) begin
            vb_wr_d.we       = 1'b1;
            vb_wr_d.idx      = fifo_head;
            vb_wr_d.way_mask = '1;
            vb_wr_d.data     = '0;
         end else if (inv_i.valid) begin
            vb_wr_d.we       = 1'b1;
            vb_wr_d.idx      = inv_idx;
            vb_wr_d.way_mask = '1;
            vb_wr_d.data     = '0;
         end
      end
      fifo_push = fifo_push_req && (!fifo_full || fifo_pop);
   end

   // Output register: every request becomes visible one cycle later
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vb_wr_q      <= '0;
         busy_q       <= c_reset_busy;
         flush_done_q <= 1'b0;
      end else begin
         vb_wr_q      <= vb_wr_d;
         busy_q       <= busy_d;
         flush_done_q <= flush_done_d;
      end
   end

   assign vb_wr_o      = vb_wr_q;
   assign busy_o       = busy_q;
   assign flush_done_o = flush_done_q;

   a_no_fill_in_sweep: assert property (@(posedge clk_i) disable iff (rst_i)
      !(fill_we_i && in_sweep));

   a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
      !(fifo_push_req && fifo_full && !fifo_pop));

endmodule
`default_nettype wire

// File: tb/tb_sargantana_icache_vb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sargantana_icache_vb_ctrl
//  Description : Directed and random stimulus for the valid-bit write-port
//                controller, checked every cycle against a transaction-level
//                model (mode + queue of pending invalidation sets).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sargantana_icache_vb_ctrl;
   import sargantana_icache_pkg::*;

   localparam int unsigned N_SETS   = ICACHE_DEPTH;
   localparam int unsigned FIFO_CAP = 2;
   localparam int M_IDLE  = 0;
   localparam int M_DRAIN = 1;
   localparam int M_SWEEP = 2;
   localparam int M_DONE  = 3;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    flush = 1'b0;
   logic                    ctrl_idle = 1'b1;
   logic                    fill_we = 1'b0;
   logic [ADDR_WIDHT-1:0]   fill_idx = '0;
   logic [ICACHE_N_WAY-1:0] fill_way = '0;
   inv_t                    inv;
   logic                    busy;
   logic                    done;
   vb_wr_t                  vb_wr;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // reference model state
   int                    m_mode;
   int                    m_set;
   bit                    m_pend;
   logic [ADDR_WIDHT-1:0] m_q[$];
   vb_wr_t                e_wr;
   logic                  e_busy;
   logic                  e_done;

   sargantana_icache_vb_ctrl #(
      .RESET_SWEEP    (1),
      .INV_FIFO_DEPTH (FIFO_CAP),
      .DEPTH          (N_SETS)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .flush_i      (flush),
      .ctrl_idle_i  (ctrl_idle),
      .fill_we_i    (fill_we),
      .fill_idx_i   (fill_idx),
      .fill_way_i   (fill_way),
      .inv_i        (inv),
      .busy_o       (busy),
      .flush_done_o (done),
      .vb_wr_o      (vb_wr)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
      $fatal(1, "watchdog");
   end

   function automatic vb_wr_t mk_wr(input logic [ADDR_WIDHT-1:0] idx,
                                    input logic [ICACHE_N_WAY-1:0] mask,
                                    input logic [ICACHE_N_WAY-1:0] data);
      vb_wr_t w;
      w.we = 1'b1; w.idx = idx; w.way_mask = mask; w.data = data;
      return w;
   endfunction

   function automatic logic [PHY_ADDR_SIZE-1:0] addr_of(input int set);
      return PHY_ADDR_SIZE'(set) << ICACHE_OFFSET_WIDTH;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk($sformatf("vb_wr@%0d", cyc), 32'(vb_wr), 32'(e_wr));
      chk($sformatf("busy@%0d", cyc), 32'(busy), 32'(e_busy));
      chk($sformatf("done@%0d", cyc), 32'(done), 32'(e_done));
   endtask

   task automatic model_reset();
      m_mode = M_SWEEP; m_set = 0; m_pend = 0; m_q.delete();
      e_wr = '0; e_busy = 1'b1; e_done = 1'b0;
   endtask

   // What the write port should carry next cycle given this cycle's inputs
   task automatic model_step();
      vb_wr_t                nxt;
      logic [ADDR_WIDHT-1:0] iidx;
      int                    old_mode;
      nxt = '0;
      iidx = ADDR_WIDHT'((inv.paddr >> ICACHE_OFFSET_WIDTH) % N_SETS);
      old_mode = m_mode;
      if (m_mode == M_SWEEP) begin
         nxt = mk_wr(ADDR_WIDHT'(m_set), '1, '0);
      end else if (fill_we) begin
         nxt = mk_wr(fill_idx, fill_way, '1);
         if (inv.valid) m_q.push_back(iidx);
      end else if (m_q.size() > 0) begin
         nxt = mk_wr(m_q.pop_front(), '1, '0);
         if (inv.valid) m_q.push_back(iidx);
      end else if (inv.valid) begin
         nxt = mk_wr(iidx, '1, '0);
      end
      e_wr   = nxt;
      e_busy = (m_mode != M_IDLE);
      e_done = (m_mode == M_DONE);
      case (m_mode)
         M_IDLE:  if (flush) m_mode = ctrl_idle ? M_SWEEP : M_DRAIN;
         M_DRAIN: if (ctrl_idle) m_mode = M_SWEEP;
         M_SWEEP: begin
            if (flush) m_pend = 1;
            m_set++;
            if (m_set == N_SETS) begin m_set = 0; m_mode = M_DONE; end
         end
         default: begin
            m_set = 0;
            if (m_pend || flush) begin m_mode = M_DRAIN; m_pend = 0; end
            else m_mode = M_IDLE;
         end
      endcase
      if (m_mode == M_SWEEP && old_mode != M_SWEEP) m_q.delete();
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      check_model();
   endtask

   task automatic run_until_idle(input int budget, input string tag);
      int n = 0;
      while ((busy !== 1'b0 || m_mode != M_IDLE) && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(n < budget), 32'd1);
   endtask

   initial begin
      int nw, nd, n;
      inv = '0;

      // ---- 1: reset and post-reset sweep
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check_model();
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= int'(N_SETS); k++) begin
         tick();
         chk("t1_sweep_idx", 32'(vb_wr), 32'(mk_wr(ADDR_WIDHT'(k - 1), '1, '0)));
      end
      tick();
      chk("t1_done_pulse", 32'(done), 32'd1);
      tick();
      chk("t1_busy_clear", 32'(busy), 32'd0);

      // ---- 2: plain fill
      fill_we = 1'b1; fill_idx = 5; fill_way = 4'b0100;
      tick();
      fill_we = 1'b0;
      chk("t2_fill", 32'(vb_wr), 32'(mk_wr(5, 4'b0100, 4'b1111)));
      tick();

      // ---- 3: fill and inv on the same set; inv lands last
      fill_we = 1'b1; fill_idx = 9; fill_way = 4'b0001;
      inv.valid = 1'b1; inv.paddr = addr_of(9);
      tick();
      fill_we = 1'b0; inv.valid = 1'b0;
      chk("t3_fill_first", 32'(vb_wr), 32'(mk_wr(9, 4'b0001, 4'b1111)));
      tick();
      chk("t3_inv_second", 32'(vb_wr), 32'(mk_wr(9, 4'b1111, 4'b0000)));
      tick();

      // ---- 4: flush while ctrl busy waits in drain
      flush = 1'b1; ctrl_idle = 1'b0;
      tick();
      flush = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t4_no_write_in_drain", 32'(vb_wr.we), 32'd0);
      end
      ctrl_idle = 1'b1;
      tick();
      chk("t4_still_quiet", 32'(vb_wr.we), 32'd0);
      tick();
      chk("t4_sweep_start", 32'(vb_wr), 32'(mk_wr(0, '1, '0)));
      run_until_idle(200, "t4_timeout");

      // ---- 5: flush at sweep index 20 triggers a second full sweep
      flush = 1'b1;
      tick();
      nw = 0; nd = 0;
      for (int k = 0; k < 400; k++) begin
         flush = (k == 20);
         tick();
         if (vb_wr.we === 1'b1) nw++;
         if (done === 1'b1) nd++;
         if (nd == 2 && busy === 1'b0) break;
      end
      flush = 1'b0;
      chk("t5_done_pulses", 32'(nd), 32'd2);
      chk("t5_sweep_writes", 32'(nw), 32'(2 * N_SETS));
      chk("t5_idle_after", 32'(busy), 32'd0);

      // ---- 6: two invs queued behind fills, then reset mid-sweep
      fill_we = 1'b1; fill_idx = 3; fill_way = 4'b0001;
      inv.valid = 1'b1; inv.paddr = addr_of(11);
      tick();
      fill_idx = 4; fill_way = 4'b0010; inv.paddr = addr_of(12);
      tick();
      fill_we = 1'b0; inv.valid = 1'b0;
      tick();
      chk("t6_inv_first", 32'(vb_wr), 32'(mk_wr(11, '1, '0)));
      tick();
      chk("t6_inv_second", 32'(vb_wr), 32'(mk_wr(12, '1, '0)));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n = 0;
      while (!(m_mode == M_SWEEP && m_set == 30) && n < 100) begin
         tick();
         n++;
      end
      chk("t6_reach_cnt30", 32'(n < 100), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("t6_rst_wr", 32'(vb_wr), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd1);
      chk("t6_rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("t6_restart_idx0", 32'(vb_wr), 32'(mk_wr(0, '1, '0)));
      run_until_idle(200, "t6_timeout");
      inv.valid = 1'b1; inv.paddr = addr_of(33);
      tick();
      inv.valid = 1'b0;
      chk("t6_fifo_empty_bypass", 32'(vb_wr), 32'(mk_wr(33, '1, '0)));

      // ---- random traffic against the model
      for (int k = 0; k < 600; k++) begin
         flush     = ($urandom_range(0, 39) == 0);
         ctrl_idle = ($urandom_range(0, 1) == 1);
         fill_we   = (m_mode != M_SWEEP) && ($urandom_range(0, 2) == 0);
         fill_idx  = ADDR_WIDHT'($urandom);
         fill_way  = ICACHE_N_WAY'(1 << $urandom_range(0, ICACHE_N_WAY - 1));
         inv.valid = ($urandom_range(0, 2) == 0);
         inv.paddr = PHY_ADDR_SIZE'($urandom);
         if (fill_we && inv.valid && m_q.size() >= FIFO_CAP) inv.valid = 1'b0;
         tick();
      end
      flush = 1'b0; fill_we = 1'b0; inv.valid = 1'b0; ctrl_idle = 1'b1;
      run_until_idle(300, "rand_timeout");
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
